// File: rtl/stage_wb_pkg.sv
// stage_wb_pkg: shared writeback/memory control field layout, encodings and datapath width
package stage_wb_pkg;
  localparam int BUS_W_DEF = 32;
  localparam int WD_RD_HI = 7;
  localparam int WD_RD_LO = 3;
  localparam int WD_WE = 2;
  localparam int WD_SRC_HI = 1;
  localparam int WD_SRC_LO = 0;
  localparam int MEM_LOAD = 4;
  localparam int MEM_UNS = 3;
  localparam int MEM_SZ_HI = 2;
  localparam int MEM_SZ_LO = 1;
  localparam int MEM_STORE = 0;
  typedef enum logic [1:0] {SRC_ALU, SRC_LOAD, SRC_PC, SRC_IMM} src_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_W3} size_e;
endpackage

// File: rtl/stage_wb_load_align.sv
// load_align: shifts the read word to the access offset, extends B/H loads and flags misaligned accesses
module load_align
  import stage_wb_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic [BUS_W-1:0] rdata,
  input  logic [1:0]       lo,
  input  logic [1:0]       size,
  input  logic             uns,
  output logic [BUS_W-1:0] val,
  output logic             mis
);
  logic [BUS_W-1:0] sh;
  logic [BUS_W-1:0] b;
  logic [BUS_W-1:0] h;
  // size 11 falls through to the word path alongside 10
  always_comb begin
    sh = rdata >> {lo, 3'b000};
    b = {{(BUS_W-8){~uns & sh[7]}}, sh[7:0]};
    h = {{(BUS_W-16){~uns & sh[15]}}, sh[15:0]};
    val = size == SZ_B ? b : size == SZ_H ? h : sh;
    mis = size == SZ_H ? lo[0] : size[1] ? |lo : 1'b0;
  end
endmodule

// File: rtl/stage_wb.sv
// stage_wb: writeback pipeline register, register-file write port and retired-instruction counter
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             validIn,
  input  logic [7:0]       wdOpIn,
  input  logic [4:0]       memOpIn,
  input  logic [1:0]       addrLoIn,
  input  logic [BUS_W-1:0] aluResIn,
  input  logic [BUS_W-1:0] memRDataIn,
  input  logic [BUS_W-1:0] pcPlusIn,
  input  logic [BUS_W-1:0] immIn,
  output logic [4:0]       regAddrOut,
  output logic             regWeOut,
  output logic [BUS_W-1:0] regWDataOut,
  output logic [63:0]      instretOut,
  output logic             misalignOut
);
  logic             v;
  logic [7:0]       wd;
  logic [4:0]       mo;
  logic [1:0]       lo;
  logic [BUS_W-1:0] alu;
  logic [BUS_W-1:0] rdat;
  logic [BUS_W-1:0] pc;
  logic [BUS_W-1:0] imm;
  logic [BUS_W-1:0] ld_val;
  logic             ld_mis;
  logic [1:0]       src;
  logic             unused_store;
  // pipeline register: flush drops the instruction, stall holds it, otherwise capture MEM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      wd <= '0;
      mo <= '0;
      lo <= '0;
      alu <= '0;
      rdat <= '0;
      pc <= '0;
      imm <= '0;
    end else if (flush) begin
      v <= 1'b0;
      wd[WD_WE] <= 1'b0;
    end else if (!stall) begin
      v <= validIn;
      wd <= wdOpIn;
      mo <= memOpIn;
      lo <= addrLoIn;
      alu <= aluResIn;
      rdat <= memRDataIn;
      pc <= pcPlusIn;
      imm <= immIn;
    end
  end
  // an instruction retires as it leaves a non-stalled WB stage; wraps silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instretOut <= '0;
    else if (v && !stall) instretOut <= instretOut + 64'd1;
  end
  load_align #(.BUS_W(BUS_W)) u_align (
    .rdata(rdat),
    .lo   (lo),
    .size (mo[MEM_SZ_HI:MEM_SZ_LO]),
    .uns  (mo[MEM_UNS]),
    .val  (ld_val),
    .mis  (ld_mis)
  );
  // writeback mux and enables, all straight off the register
  always_comb begin
    src = wd[WD_SRC_HI:WD_SRC_LO];
    unused_store = mo[MEM_STORE];
    regAddrOut = wd[WD_RD_HI:WD_RD_LO];
    misalignOut = v & mo[MEM_LOAD] & ld_mis;
    regWeOut = v & wd[WD_WE] & (|regAddrOut) & ~misalignOut;
    regWDataOut = src == SRC_ALU ? alu : src == SRC_LOAD ? ld_val : src == SRC_PC ? pc : imm;
  end
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: vector table plus multi-cycle sequences, scoreboard-checked against stage_wb
module tb_stage_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        validIn = 1'b0;
  logic [7:0]  wdOpIn = '0;
  logic [4:0]  memOpIn = '0;
  logic [1:0]  addrLoIn = '0;
  logic [31:0] aluResIn = '0;
  logic [31:0] memRDataIn = '0;
  logic [31:0] pcPlusIn = '0;
  logic [31:0] immIn = '0;
  logic [4:0]  regAddrOut;
  logic        regWeOut;
  logic [31:0] regWDataOut;
  logic [63:0] instretOut;
  logic        misalignOut;

  stage_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validIn(validIn),
    .wdOpIn(wdOpIn), .memOpIn(memOpIn), .addrLoIn(addrLoIn),
    .aluResIn(aluResIn), .memRDataIn(memRDataIn), .pcPlusIn(pcPlusIn), .immIn(immIn),
    .regAddrOut(regAddrOut), .regWeOut(regWeOut), .regWDataOut(regWDataOut),
    .instretOut(instretOut), .misalignOut(misalignOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  wd;
    logic [4:0]  mo;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
    logic        cd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
    logic        cd;
    logic [63:0] ir;
  } exp_t;

  exp_t sb[$];
  vec_t tv[15];
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] cnt = '0;
  logic mvalid = 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step(input string n, input vec_t v, input logic st, input logic fl);
    exp_t e;
    validIn = v.valid;
    wdOpIn = v.wd;
    memOpIn = v.mo;
    addrLoIn = v.lo;
    aluResIn = v.alu;
    memRDataIn = v.rdat;
    pcPlusIn = v.pc;
    immIn = v.imm;
    stall = st;
    flush = fl;
    if (mvalid && !st) cnt = cnt + 64'd1;
    if (fl) mvalid = 1'b0;
    else if (!st) mvalid = v.valid;
    e = '{v.we, v.addr, v.data, v.mis, v.cd, cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({n, ".we"}, 64'(regWeOut), 64'(e.we));
    chk({n, ".mis"}, 64'(misalignOut), 64'(e.mis));
    chk({n, ".instret"}, instretOut, e.ir);
    if (e.cd) begin
      chk({n, ".addr"}, 64'(regAddrOut), 64'(e.addr));
      chk({n, ".data"}, 64'(regWDataOut), 64'(e.data));
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, ".we"}, 64'(regWeOut), 64'd0);
    chk({n, ".addr"}, 64'(regAddrOut), 64'd0);
    chk({n, ".data"}, 64'(regWDataOut), 64'd0);
    chk({n, ".instret"}, instretOut, 64'd0);
    chk({n, ".mis"}, 64'(misalignOut), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    vec_t va, vs, vf, vb;
    tv[0]  = '{1'b1, {5'd5, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b1};
    tv[1]  = '{1'b1, {5'd6, 1'b1, 2'b01}, 5'b10000, 2'd3, 32'h0, 32'h80FFFFFF, 32'h0, 32'h0, 1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 1'b1};
    tv[2]  = '{1'b1, {5'd6, 1'b1, 2'b01}, 5'b11000, 2'd3, 32'h0, 32'h80FFFFFF, 32'h0, 32'h0, 1'b1, 5'd6, 32'h00000080, 1'b0, 1'b1};
    tv[3]  = '{1'b1, {5'd7, 1'b1, 2'b01}, 5'b10010, 2'd1, 32'h0, 32'h80FFFFFF, 32'h0, 32'h0, 1'b0, 5'd7, 32'hFFFFFFFF, 1'b1, 1'b1};
    tv[4]  = '{1'b1, {5'd8, 1'b1, 2'b01}, 5'b10100, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[5]  = '{1'b1, {5'd0, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h55, 1'b0, 1'b1};
    tv[6]  = '{1'b1, {5'd9, 1'b1, 2'b10}, 5'b00000, 2'd0, 32'h1, 32'h0, 32'h1004, 32'h0, 1'b1, 5'd9, 32'h1004, 1'b0, 1'b1};
    tv[7]  = '{1'b1, {5'd10, 1'b1, 2'b11}, 5'b00000, 2'd0, 32'h1, 32'h0, 32'h0, 32'hFFFFF000, 1'b1, 5'd10, 32'hFFFFF000, 1'b0, 1'b1};
    tv[8]  = '{1'b1, {5'd11, 1'b1, 2'b01}, 5'b11010, 2'd2, 32'h0, 32'h80011234, 32'h0, 32'h0, 1'b1, 5'd11, 32'h00008001, 1'b0, 1'b1};
    tv[9]  = '{1'b1, {5'd11, 1'b1, 2'b01}, 5'b10010, 2'd2, 32'h0, 32'h80011234, 32'h0, 32'h0, 1'b1, 5'd11, 32'hFFFF8001, 1'b0, 1'b1};
    tv[10] = '{1'b1, {5'd12, 1'b1, 2'b01}, 5'b10110, 2'd0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 1'b1};
    tv[11] = '{1'b1, {5'd13, 1'b1, 2'b01}, 5'b10100, 2'd3, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0, 5'd13, 32'h0, 1'b1, 1'b0};
    tv[12] = '{1'b0, {5'd3, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 32'h77, 1'b0, 1'b1};
    tv[13] = '{1'b1, {5'd14, 1'b1, 2'b00}, 5'b00101, 2'd1, 32'h99, 32'h0, 32'h0, 32'h0, 1'b1, 5'd14, 32'h99, 1'b0, 1'b1};
    tv[14] = '{1'b1, {5'd15, 1'b0, 2'b00}, 5'b00000, 2'd0, 32'hAA, 32'h0, 32'h0, 32'h0, 1'b0, 5'd15, 32'hAA, 1'b0, 1'b1};
    va = '{1'b1, {5'd20, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h1111, 32'h0, 32'h0, 32'h0, 1'b1, 5'd20, 32'h1111, 1'b0, 1'b1};
    vs = '{1'b1, {5'd21, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h2222, 32'h0, 32'h0, 32'h0, 1'b1, 5'd20, 32'h1111, 1'b0, 1'b1};
    vf = '{1'b1, {5'd21, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h2222, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
    vb = '{1'b1, {5'd21, 1'b1, 2'b00}, 5'b00000, 2'd0, 32'h2222, 32'h0, 32'h0, 32'h0, 1'b1, 5'd21, 32'h2222, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tv[i], 1'b0, 1'b0);

    step("stall_load", va, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), vs, 1'b1, 1'b0);
    step("stall_flush", vf, 1'b1, 1'b1);
    step("after_flush", vb, 1'b0, 1'b0);
    step("after_flush2", tv[0], 1'b0, 1'b0);

    rst = 1'b0;
    #1;
    chk_zero("midreset");
    cnt = '0;
    mvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step("post_reset0", tv[0], 1'b0, 1'b0);
    step("post_reset1", tv[4], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
